// File: rtl/adc_sample_fifo.sv
`default_nettype none
// ============================================================================
// adc_sample_fifo : decimating first-word-fall-through FIFO that buffers ADC
//                   samples for the CPU input port, with sticky overflow.
// Revision 1.0
// ============================================================================
module adc_sample_fifo #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 8,
  parameter int DECIM  = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DWIDTH-1:0]       adc_in,
  input  logic                    adc_valid,
  output logic [DWIDTH-1:0]       adcdata,
  output logic                    adcdata_valid,
  input  logic                    input_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic [7:0]              drop_count,
  input  logic                    clear_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CW-1:0] C_DEC_LAST = CW'(DECIM - 1);
  localparam logic [PW-1:0] C_FULL_XOR = {1'b1, {AW{1'b0}}};

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr, r_level;
  logic [DWIDTH-1:0] r_adcdata;
  logic [CW-1:0]     r_dec_cnt;
  logic              r_overflow;
  logic [7:0]        r_drop_count;

  logic              w_empty, w_full, w_pop, w_keep, w_push, w_drop;
  logic [PW-1:0]     w_wr_next, w_rd_next;
  logic [DWIDTH-1:0] w_head_next;

  always_comb begin
    w_empty   = (r_wr_ptr == r_rd_ptr);
    w_full    = ((r_wr_ptr ^ r_rd_ptr) == C_FULL_XOR);
    w_pop     = !w_empty && input_ready;
    w_keep    = adc_valid && (r_dec_cnt == '0);
    w_push    = w_keep && (!w_full || w_pop);
    w_drop    = w_keep && w_full && !w_pop;
    w_wr_next = r_wr_ptr + PW'(w_push);
    w_rd_next = r_rd_ptr + PW'(w_pop);
    // The incoming sample becomes the head only when it lands in the slot the
    // read pointer will point at, i.e. the FIFO is (or becomes) empty.
    w_head_next = (w_push && (w_rd_next == r_wr_ptr)) ? adc_in
                                                      : r_mem[w_rd_next[AW-1:0]];
  end

  always_ff @(posedge clock) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= adc_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_adcdata    <= '0;
      r_dec_cnt    <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_wr_ptr <= w_wr_next;
      r_rd_ptr <= w_rd_next;
      r_level  <= w_wr_next - w_rd_next;
      // adcdata holds its last value once the FIFO drains.
      if (w_wr_next != w_rd_next) begin
        r_adcdata <= w_head_next;
      end
      if (adc_valid) begin
        r_dec_cnt <= (r_dec_cnt == C_DEC_LAST) ? '0 : r_dec_cnt + 1'b1;
      end
      if (clear_overflow) begin
        r_overflow   <= 1'b0;
        r_drop_count <= '0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 8'hFF) begin
          r_drop_count <= r_drop_count + 8'd1;
        end
      end
    end
  end

  assign adcdata       = r_adcdata;
  assign adcdata_valid = !w_empty;
  assign level         = r_level;
  assign overflow      = r_overflow;
  assign drop_count    = r_drop_count;

endmodule
`default_nettype wire
